note_chart_player: RTL and testbench

- Parametrised successor to the fixed-song eighth-note sender.
- Plays a loadable note chart (one LANES-bit chord per step) at a programmable step rate.
- Supports pause, restart and loop.
- Exposes a LOOKAHEAD-deep window of upcoming steps so the scrolling-highway renderer and the hit judge can read future notes.
- Sits between chart loader/SW controls and the display/scoring logic.

---
 rtl/note_chart_player.sv | 176 +++++++++++++++++
 tb/tb_note_chart_player.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/note_chart_player.sv
// Note chart player: plays a loadable LANES-wide chord chart at a programmable
// step rate, with pause / restart / loop, and exposes a LOOKAHEAD-deep window
// of upcoming chords for the highway renderer and hit judge.
//
// Ports:
//   CLOCK_50    sole clock
//   resetn      async active-low reset (chart memory is retained)
//   start       pulse: (re)start playback from step 0, latches loop_en
//   pause       level: freeze playback while high
//   loop_en     wrap to step 0 after the last step (sampled on start)
//   wr_en/wr_addr/wr_data  chart memory write port (addr >= STEPS ignored)
//   exp_notes   current chord (window slot 0)
//   window      slot k = [k*LANES +: LANES] = chord for step+k
//   step        current step index
//   step_pulse  one-cycle pulse when a new step becomes current
//   playing     high in PLAY or PAUSE
//   done        high once a non-looping chart has finished
module note_chart_player #(
  parameter int unsigned LANES     = 5,
  parameter int unsigned STEPS     = 304,
  parameter int unsigned STEP_W    = 9,
  parameter int unsigned TICK_DIV  = 13157895,
  parameter int unsigned DIV_W     = 25,
  parameter int unsigned LOOKAHEAD = 8
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic                         start,
  input  logic                         pause,
  input  logic                         loop_en,
  input  logic                         wr_en,
  input  logic [STEP_W-1:0]            wr_addr,
  input  logic [LANES-1:0]             wr_data,
  output logic [LANES-1:0]             exp_notes,
  output logic [LOOKAHEAD*LANES-1:0]   window,
  output logic [STEP_W-1:0]            step,
  output logic                         step_pulse,
  output logic                         playing,
  output logic                         done
);

  localparam int unsigned WIN_W = LOOKAHEAD * LANES;
  localparam int unsigned FP_W  = STEP_W + 1;
  localparam int unsigned AW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned PC_W  = $clog2(LOOKAHEAD + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state, state_nx;
  logic              loop_l;
  logic [FP_W-1:0]   fptr, fptr_inc;
  logic [PC_W-1:0]   pcnt;
  logic [DIV_W-1:0]  tick;
  logic [LANES-1:0]  rd_data;
  logic              rd_vld;
  logic              rd_win;
  logic [LANES-1:0]  pf;
  logic              run, adv, last, prime_end, rd_req;

  logic [LANES-1:0]  mem [STEPS];

  // Chart memory write port; not reset so the chart survives resetn.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en && ({1'b0, wr_addr} < FP_W'(STEPS)))
      mem[AW'(wr_addr)] <= wr_data;
  end

  // Fetch pointer successor: wraps when looping, otherwise parks at STEPS
  // so every further fetch returns an empty chord.
  always_comb begin
    fptr_inc = fptr + FP_W'(1);
    if (loop_l) begin
      if (fptr >= FP_W'(STEPS - 1)) fptr_inc = '0;
    end else if (fptr >= FP_W'(STEPS)) begin
      fptr_inc = fptr;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    run       = ((state == S_PLAY) || (state == S_PAUSE)) && !pause;
    adv       = run && (tick == DIV_W'(TICK_DIV - 1));
    last      = (step == STEP_W'(STEPS - 1));
    prime_end = (state == S_PRIME) && (pcnt == PC_W'(LOOKAHEAD));
    rd_req    = !start && ((state == S_PRIME) || adv);
    state_nx  = state;
    if (start) begin
      state_nx = S_PRIME;
    end else begin
      case (state)
        S_PRIME: if (prime_end) state_nx = pause ? S_PAUSE : S_PLAY;
        S_PLAY, S_PAUSE: begin
          if (adv && last && !loop_l) state_nx = S_DONE;
          else                        state_nx = pause ? S_PAUSE : S_PLAY;
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Datapath: fetch pipeline, window shifter, step/tick counters.
  // The final PRIME read (pcnt == LOOKAHEAD) lands in pf as the prefetch for
  // the first advance; every advance then refills pf for the following one.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      loop_l     <= 1'b0;
      fptr       <= '0;
      pcnt       <= '0;
      tick       <= '0;
      rd_data    <= '0;
      rd_vld     <= 1'b0;
      rd_win     <= 1'b0;
      pf         <= '0;
      window     <= '0;
      step       <= '0;
      step_pulse <= 1'b0;
      playing    <= 1'b0;
      done       <= 1'b0;
    end else begin
      playing <= (state_nx == S_PLAY) || (state_nx == S_PAUSE);
      done    <= (state_nx == S_DONE);
      if (fptr < FP_W'(STEPS)) rd_data <= mem[AW'(fptr)];
      else                     rd_data <= '0;

      if (start) begin
        loop_l     <= loop_en;
        fptr       <= '0;
        pcnt       <= '0;
        tick       <= '0;
        rd_vld     <= 1'b0;
        rd_win     <= 1'b0;
        pf         <= '0;
        window     <= '0;
        step       <= '0;
        step_pulse <= 1'b0;
      end else begin
        step_pulse <= 1'b0;
        rd_vld     <= rd_req;
        rd_win     <= (state == S_PRIME) && !prime_end;
        if (rd_req) fptr <= fptr_inc;

        if (state == S_PRIME) begin
          if (prime_end) step_pulse <= 1'b1;
          else           pcnt <= pcnt + PC_W'(1);
        end

        if (rd_vld && rd_win)  window <= {rd_data, window[WIN_W-1:LANES]};
        if (rd_vld && !rd_win) pf     <= rd_data;

        if (run) tick <= adv ? '0 : tick + DIV_W'(1);

        if (adv) begin
          if (last && !loop_l) begin
            window <= '0;
          end else begin
            window     <= {pf, window[WIN_W-1:LANES]};
            step       <= last ? '0 : step + STEP_W'(1);
            step_pulse <= 1'b1;
          end
        end
      end
    end
  end

  assign exp_notes = window[LANES-1:0];

endmodule

// File: tb/tb_note_chart_player.sv
module tb_note_chart_player;
  localparam int unsigned LANES    = 5;
  localparam int unsigned STEPS    = 6;
  localparam int unsigned STEP_W   = 3;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned DIV_W    = 3;
  localparam int unsigned LA       = 3;
  localparam int unsigned WW       = LA * LANES;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic              pause = 1'b0;
  logic              loop_en = 1'b0;
  logic              wr_en = 1'b0;
  logic [STEP_W-1:0] wr_addr = '0;
  logic [LANES-1:0]  wr_data = '0;
  logic [LANES-1:0]  exp_notes;
  logic [WW-1:0]     window;
  logic [STEP_W-1:0] step;
  logic              step_pulse, playing, done;

  note_chart_player #(
    .LANES(LANES), .STEPS(STEPS), .STEP_W(STEP_W),
    .TICK_DIV(TICK_DIV), .DIV_W(DIV_W), .LOOKAHEAD(LA)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .pause(pause),
    .loop_en(loop_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .exp_notes(exp_notes), .window(window), .step(step),
    .step_pulse(step_pulse), .playing(playing), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: mode, current step, position within the step,
  // and a copy of the chart. The window is derived directly from the chart.
  typedef enum int {M_IDLE, M_PRIME, M_PLAY, M_PAUSE, M_DONE} mode_t;
  mode_t      m_mode = M_IDLE;
  int         m_step = 0;
  int         m_tick = 0;
  int         m_cnt  = 0;
  bit         m_loop = 1'b0;
  bit         m_pulse = 1'b0;
  logic [4:0] m_mem [STEPS];

  function automatic logic [WW-1:0] exp_window();
    logic [WW-1:0] w = '0;
    if (m_mode == M_PLAY || m_mode == M_PAUSE) begin
      for (int k = 0; k < int'(LA); k++) begin
        int idx = m_step + k;
        if (m_loop) idx = idx % int'(STEPS);
        if (idx < int'(STEPS)) w[k*LANES +: LANES] = m_mem[idx];
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_step = 0; m_tick = 0; m_cnt = 0; m_loop = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_edge();
    if (wr_en && int'(wr_addr) < int'(STEPS)) m_mem[wr_addr] = wr_data;
    if (start) begin
      m_mode = M_PRIME; m_cnt = 0; m_loop = loop_en; m_step = 0; m_tick = 0; m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      case (m_mode)
        M_PRIME: begin
          m_cnt++;
          if (m_cnt == int'(LA) + 1) begin
            m_mode  = pause ? M_PAUSE : M_PLAY;
            m_pulse = 1'b1;
          end
        end
        M_PLAY, M_PAUSE: begin
          if (!pause) begin
            if (m_tick == int'(TICK_DIV) - 1) begin
              m_tick = 0;
              if (m_step == int'(STEPS) - 1) begin
                if (m_loop) begin m_step = 0; m_pulse = 1'b1; end
                else m_mode = M_DONE;
              end else begin
                m_step++; m_pulse = 1'b1;
              end
            end else begin
              m_tick++;
            end
          end
          if (m_mode != M_DONE) m_mode = pause ? M_PAUSE : M_PLAY;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    logic [WW-1:0] w;
    w = exp_window();
    check("step", 32'(step), 32'(m_step));
    check("step_pulse", 32'(step_pulse), 32'(m_pulse));
    check("playing", 32'(playing), 32'(m_mode == M_PLAY || m_mode == M_PAUSE));
    check("done", 32'(done), 32'(m_mode == M_DONE));
    if (m_mode != M_PRIME) begin
      check("window", 32'(window), 32'(w));
      check("exp_notes", 32'(exp_notes), 32'(w[LANES-1:0]));
    end
  endtask

  // One clock: drive inputs (from a negedge), model the edge, check at negedge.
  task automatic cyc(input bit st, input bit ps, input bit we, input int wa, input int wd);
    start = st; pause = ps; wr_en = we;
    wr_addr = STEP_W'(wa); wr_data = LANES'(wd);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic async_reset();
    start = 1'b0; pause = 1'b0; wr_en = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("rst_step", 32'(step), 32'd0);
    check("rst_window", 32'(window), 32'd0);
    check("rst_flags", 32'({step_pulse, playing, done}), 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  int chart [STEPS] = '{32'h01, 32'h02, 32'h04, 32'h08, 32'h10, 32'h1F};

  initial begin
    bit ps;
    int guard;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    resetn = 1'b1;
    for (int i = 0; i < int'(STEPS); i++) cyc(1'b0, 1'b0, 1'b1, i, chart[i]);

    // Non-looping run.
    loop_en = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    idle(4);
    check("entry_window", 32'(window), 32'h1041);
    check("entry_pulse", 32'(step_pulse), 32'd1);
    idle(16);
    check("step4_window", 32'(window), 32'h03F0);
    idle(8);
    check("done_flag", 32'(done), 32'd1);
    check("done_notes", 32'(exp_notes), 32'd0);
    idle(6);

    // Looping run, then pause mid-step.
    loop_en = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    loop_en = 1'b0;
    idle(20);
    check("loop_step4_window", 32'(window), 32'h07F0);
    idle(8);
    check("loop_wrap_step", 32'(step), 32'd0);
    check("loop_wrap_notes", 32'(exp_notes), 32'h01);
    idle(2);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 0, 0);
    idle(2);
    check("pause_resume_pulse", 32'(step_pulse), 32'd1);
    check("pause_resume_step", 32'(step), 32'd1);

    // Restart coinciding with an advance from step 3.
    guard = 0;
    while (!(m_step == 3 && m_tick == int'(TICK_DIV) - 1) && guard < 200) begin
      idle(1); guard++;
    end
    check("reach_step3", 32'(guard < 200), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    idle(4);
    check("restart_step", 32'(step), 32'd0);
    check("restart_notes", 32'(exp_notes), 32'h01);

    // Chart edits and reset retention.
    async_reset();
    cyc(1'b0, 1'b0, 1'b1, 2, 32'h1B);
    cyc(1'b0, 1'b0, 1'b1, 7, 32'h0A);
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    idle(12);
    check("edit_notes", 32'(exp_notes), 32'h1B);
    idle(3);
    async_reset();
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    idle(12);
    check("retain_notes", 32'(exp_notes), 32'h1B);

    // Randomised operation against the reference model.
    ps = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit st, we;
      if (i == 1500) async_reset();
      if ($urandom_range(0, 19) == 0) ps = ~ps;
      st = ($urandom_range(0, 49) == 0) || (m_mode == M_IDLE && $urandom_range(0, 3) == 0);
      loop_en = 1'($urandom_range(0, 1));
      we = (m_mode == M_IDLE || m_mode == M_DONE) && ($urandom_range(0, 2) == 0);
      cyc(st, ps, we, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
